// File: rtl/clk_period_meter_pkg.sv
// clk_period_meter_pkg: shared state encoding and default sizes for the slow-clock period meter.
`default_nettype none

package clk_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        LOCKED = 2'b10,
        LOST   = 2'b11
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

endpackage

`default_nettype wire

// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: slow-clock input plus edge, period and lock status outputs.
`default_nettype none

interface clk_period_meter_if
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             sig_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lost;
    logic [7:0]       edge_count;

    modport master (
        output sig_in,
        input  rise_pulse, fall_pulse, period, period_valid, locked, lost, edge_count
    );

    modport slave (
        input  sig_in,
        output rise_pulse, fall_pulse, period, period_valid, locked, lost, edge_count
    );

endinterface

`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an asynchronous slow clock with rise/fall event decode.
`default_nettype none

module sync_edge_det
    import clk_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  wire logic clockin,
    input  wire logic reset,
    input  wire logic sig_i,
    output logic      rise_ev_o,
    output logic      fall_ev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s_last;

    assign s_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= s_last;
        end
    end

    assign rise_ev_o =  s_last & ~prev_q;
    assign fall_ev_o = ~s_last &  prev_q;

endmodule

`default_nettype wire

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures rising-to-rising period of a slow asynchronous clock,
// emits edge enables and tracks lock / loss of that clock.
`default_nettype none

module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = 50000
) (
    input  wire logic        clockin,
    input  wire logic        reset,
    clk_period_meter_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    logic rise_ev;
    logic fall_ev;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q,     pv_d;
    logic             rise_q,   fall_q;
    logic [7:0]       ec_q,     ec_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clockin   (clockin),
        .reset     (reset),
        .sig_i     (bus.sig_in),
        .rise_ev_o (rise_ev),
        .fall_ev_o (fall_ev)
    );

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            ec_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            rise_q   <= rise_ev;
            fall_q   <= fall_ev;
            ec_q     <= ec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        ec_d     = ec_q;

        // cnt holds the cycles elapsed since the last rise, so its pre-update value is the period
        if (rise_ev) begin
            cnt_d = CNT_W'(1);
            ec_d  = ec_q + 8'd1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rise_ev) state_d = ARMED;
            end
            ARMED, LOCKED: begin
                if (rise_ev) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    state_d  = LOCKED;
                end else if (cnt_q == TIMEOUT_V) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (rise_ev) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rise_pulse   = rise_q;
    assign bus.fall_pulse   = fall_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.lost         = (state_q == LOST);
    assign bus.edge_count   = ec_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed and randomized stimulus checked against an edge-timeline model.
`default_nettype none

module tb_clk_period_meter;

    localparam int SYNC  = 2;
    localparam int CW    = 8;
    localparam int TMO   = 200;

    logic clockin = 1'b0;
    logic reset   = 1'b1;

    clk_period_meter_if #(.CNT_W(CW)) bus ();

    clk_period_meter #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clockin (clockin),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clockin = ~clockin;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: sig_in value captured at each clock edge since reset release
    bit samp[$];
    int last_rise;
    bit last_valid;
    int e_period, e_ec;
    bit e_rise, e_fall, e_pv, e_locked, e_lost;

    function automatic bit smp(input int i);
        return (i < 0) ? 1'b0 : samp[i];
    endfunction

    task automatic model_clear();
        samp.delete();
        last_rise  = -1;
        last_valid = 1'b0;
        e_period   = 0;
        e_ec       = 0;
        e_rise     = 1'b0;
        e_fall     = 1'b0;
        e_pv       = 1'b0;
        e_locked   = 1'b0;
        e_lost     = 1'b0;
    endtask

    task automatic model_edge(input bit v);
        int  n;
        bit  cur, old, valid;
        samp.push_back(v);
        n      = samp.size() - 1;
        cur    = smp(n - SYNC);
        old    = smp(n - SYNC - 1);
        e_rise = cur & ~old;
        e_fall = ~cur & old;
        e_pv   = 1'b0;
        if (e_rise) begin
            valid = (last_rise >= 0) && ((n - last_rise) <= TMO);
            if (valid) begin
                e_period = n - last_rise;
                e_pv     = 1'b1;
            end
            last_valid = valid;
            last_rise  = n;
            e_ec       = (e_ec + 1) % 256;
        end
        e_locked = (last_rise >= 0) && last_valid && ((n - last_rise) < TMO);
        e_lost   = (last_rise >= 0) && ((n - last_rise) >= TMO);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rise_pulse",   32'(bus.rise_pulse),   32'(e_rise));
        chk("fall_pulse",   32'(bus.fall_pulse),   32'(e_fall));
        chk("period_valid", 32'(bus.period_valid), 32'(e_pv));
        chk("period",       32'(bus.period),       32'(e_period));
        chk("locked",       32'(bus.locked),       32'(e_locked));
        chk("lost",         32'(bus.lost),         32'(e_lost));
        chk("edge_count",   32'(bus.edge_count),   32'(e_ec));
    endtask

    // Called at a falling edge; leaves the bench at a falling edge
    task automatic tick(input bit nv);
        bus.sig_in = nv;
        @(posedge clockin);
        model_edge(nv);
        @(negedge clockin);
        check_all();
    endtask

    task automatic wave(input int hi, input int lo, input int count);
        repeat (count) begin
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge
    task automatic async_reset(input int hold_edges);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        repeat (hold_edges) begin
            @(negedge clockin);
            bus.sig_in = ~bus.sig_in;
        end
        @(negedge clockin);
        check_all();
        bus.sig_in = 1'b0;
        reset      = 1'b0;
    endtask

    initial begin
        bus.sig_in = 1'b0;
        model_clear();
        #1;
        check_all();
        repeat (2) @(negedge clockin);
        reset = 1'b0;

        // Mid-run async reset with sig_in toggling, then idle low
        wave(3, 3, 5);
        async_reset(4);
        repeat (10) tick(1'b0);
        chk("idle_locked", 32'(bus.locked), 32'd0);

        // First sampled high at edge 0: pulse only after edge 2
        tick(1'b1);
        chk("lat_rise_e0", 32'(bus.rise_pulse), 32'd0);
        tick(1'b1);
        chk("lat_rise_e1", 32'(bus.rise_pulse), 32'd0);
        tick(1'b1);
        chk("lat_rise_e2", 32'(bus.rise_pulse), 32'd1);
        repeat (5) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        chk("lat_fall_e1", 32'(bus.fall_pulse), 32'd0);
        tick(1'b0);
        chk("lat_fall_e2", 32'(bus.fall_pulse), 32'd1);
        repeat (5) tick(1'b0);

        // 8/8 square wave locks with period 16
        wave(8, 8, 6);
        chk("sq_period", 32'(bus.period), 32'd16);
        chk("sq_locked", 32'(bus.locked), 32'd1);

        // Loss of clock, then recovery
        repeat (230) tick(1'b0);
        chk("gap_lost",   32'(bus.lost),   32'd1);
        chk("gap_period", 32'(bus.period), 32'd16);
        wave(8, 8, 4);
        chk("rec_locked", 32'(bus.locked), 32'd1);

        // Spacing exactly at the timeout, then one beyond
        wave(100, 100, 4);
        chk("t200_period", 32'(bus.period), 32'd200);
        wave(101, 100, 3);

        // Edge counter wrap, then reset while locked
        wave(8, 8, 260);
        async_reset(0);
        wave(8, 8, 2);

        // Randomized half-periods, occasionally long enough to time out
        repeat (25) begin
            int hi, lo;
            if ($urandom_range(0, 5) == 0) begin
                hi = int'($urandom_range(80, 130));
                lo = int'($urandom_range(80, 130));
            end else begin
                hi = int'($urandom_range(2, 30));
                lo = int'($urandom_range(2, 30));
            end
            wave(hi, lo, int'($urandom_range(1, 4)));
        end
        repeat (5) tick(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
